switch_press_detect: RTL and testbench
======================================

// Module: switch_press_detect
// PURPOSE
//  Receiving end of a switch line: takes a raw, possibly bouncing, switch level (physical
//  button or the switch-emulation output) and converts it to a clean debounced level plus a
//  single-cycle press pulse. It also flags a switch held on longer than the allowed hold time.
//  Sits between the board switch pins and the control FSMs that expect one-clock strobes.
// PARAMETERS
//  DEB_CYCLES  1000  consecutive stable cycles needed to accept a level change; must be >= 2
//  DEB_W       16    width of deb_cnt; 2^DEB_W must be > DEB_CYCLES
//  HOLD_W      26    width of hold_cnt; stuck limit = 2^(HOLD_W-1) cycles in ON/DEB_OFF
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  sw_in      in   1  raw switch level (asynchronous, 1 = pressed)
//  level_out  out  1  debounced switch level
//  pulse_out  out  1  one-cycle strobe per accepted press
//  stuck_err  out  1  sticky flag: switch held beyond the stuck limit
// BEHAVIOUR
//  - Reset: clk and rst only; reset is synchronous and active-high. While rst=1 on an edge:
//    state=IDLE, sync FFs=0, counters=0, level_out=0, pulse_out=0, stuck_err=0.
//    Reset mid-press aborts it. A press is re-detected only after sw_s is seen low then high.
//  - Sync: sw_in -> 2 FF chain -> sw_s. No logic between the FFs.
//  - FSM: one-hot states IDLE, DEB_ON, ON, DEB_OFF. Illegal state -> IDLE, counters cleared.
//   IDLE   : deb_cnt=0, hold_cnt=0. sw_s=1 -> DEB_ON.
//   DEB_ON : sw_s=0 -> IDLE (glitch rejected, no output change).
//            sw_s=1 and deb_cnt==DEB_CYCLES-1 -> ON, level_out<=1, pulse_out<=1, deb_cnt<=0.
//            Otherwise deb_cnt++.
//   ON     : hold_cnt++ (saturates at all-ones). sw_s=0 -> DEB_OFF, deb_cnt<=0.
//   DEB_OFF: hold_cnt++ (saturating). sw_s=1 -> ON (release bounce, no new pulse).
//            sw_s=0 and deb_cnt==DEB_CYCLES-1 -> IDLE, level_out<=0. Otherwise deb_cnt++.
//  - Latency: edge N is the first edge that samples sw_in=1, and sw_in stays high.
//    level_out and pulse_out rise after edge N+DEB_CYCLES+2. Release is symmetric:
//    level_out falls after edge M+DEB_CYCLES+2.
//  - pulse_out is high for exactly one cycle per IDLE..IDLE episode. It is never high on
//    two consecutive cycles.
//  - stuck_err is set on the edge where hold_cnt[HOLD_W-1] first reads 1. It stays set
//    until rst; release and new presses do not clear it. Detection continues normally.
//  - Counters never wrap. deb_cnt resets on every state change; hold_cnt saturates.
// CONFIGURATION
//  SWDET_RELEASE_PULSE_EN
//   - Undefined (default): pulse_out fires on the DEB_ON -> ON transition (press).
//   - Defined: pulse_out fires on the DEB_OFF -> IDLE transition (release), one cycle,
//     coincident with level_out falling.
//   - Either way, a press aborted by rst produces no pulse.
//   - level_out and stuck_err are identical in both builds.
// TESTING  (DEB_CYCLES=4, HOLD_W=6 unless noted)
//  1. sw_in=1 from edge N for 20 cycles, then 0 -> pulse_out=1 for exactly 1 cycle after
//     edge N+6. level_out=1 from N+6 until 6 edges after the first low sample.
//  2. sw_in high 3 cycles, then low -> pulse_out and level_out stay 0. FSM returns to IDLE.
//  3. Press accepted, then sw_in low 2 cycles, high 10, low 20 -> single pulse, level_out
//     stays 1 through the bounce, then falls once.
//  4. sw_in held 50 cycles -> stuck_err=1 once hold_cnt hits 32. It stays 1 after release
//     and after a second clean press (second press still gives 1 pulse). rst clears it.
//  5. rst=1 for 1 cycle while in DEB_ON, then ON -> outputs 0 after that edge. With sw_in
//     held high, no pulse until sw_in is seen low then high again.
//  6. SWDET_RELEASE_PULSE_EN defined, repeat 1 -> no pulse at N+6. One pulse coincides
//     with the level_out falling edge.

Source files
------------

// File: rtl/switch_press_detect.sv
// Debounces a raw switch level into a clean level, a one-cycle press strobe and a sticky stuck flag.
// Define SWDET_RELEASE_PULSE_EN to move the strobe from the press to the release transition.
module switch_press_detect #(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned HOLD_W     = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic level_out,
  output logic pulse_out,
  output logic stuck_err
);

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StDebOn  = 4'b0010,
    StOn     = 4'b0100,
    StDebOff = 4'b1000
  } state_e;

  localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, sw_s;
  logic [1:0]        vld_q;
  logic              armed_q, armed_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic              stuck_q, stuck_d;

  assign sw_s      = sync2_q;
  assign hold_inc  = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
  assign level_out = level_q;
  assign pulse_out = pulse_q;
  assign stuck_err = stuck_q;

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    pulse_d    = 1'b0;
    stuck_d    = stuck_q | hold_cnt_q[HOLD_W-1];
    // Only a low seen after the synchroniser refills post-reset re-arms detection.
    armed_d    = armed_q | (vld_q[1] & ~sw_s);
    unique case (state_q)
      StIdle: begin
        deb_cnt_d  = '0;
        hold_cnt_d = '0;
        if (sw_s && armed_q) state_d = StDebOn;
      end
      StDebOn: begin
        if (!sw_s) begin
          state_d   = StIdle;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = StOn;
          level_d   = 1'b1;
          deb_cnt_d = '0;
`ifndef SWDET_RELEASE_PULSE_EN
          pulse_d   = 1'b1;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      StOn: begin
        hold_cnt_d = hold_inc;
        deb_cnt_d  = '0;
        if (!sw_s) state_d = StDebOff;
      end
      StDebOff: begin
        hold_cnt_d = hold_inc;
        if (sw_s) begin
          state_d   = StOn;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d   = StIdle;
          level_d   = 1'b0;
          deb_cnt_d = '0;
`ifdef SWDET_RELEASE_PULSE_EN
          pulse_d   = 1'b1;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        deb_cnt_d  = '0;
        hold_cnt_d = '0;
        level_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      pulse_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sw_in;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      armed_q    <= armed_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      stuck_q    <= stuck_d;
    end
  end

endmodule

// File: tb/tb_switch_press_detect.sv
// Scoreboard bench for switch_press_detect: a run-length reference model queues expected outputs,
// a monitor pops and compares them every cycle.
module tb_switch_press_detect;

  localparam int unsigned Deb       = 4;
  localparam int unsigned HoldW     = 6;
  localparam int          HoldLimit = 1 << (HoldW - 1);
  localparam int          HoldMax   = (1 << HoldW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_in = 1'b0;
  logic level_out, pulse_out, stuck_err;

  switch_press_detect #(
    .DEB_CYCLES(Deb),
    .DEB_W     (8),
    .HOLD_W    (HoldW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .level_out(level_out),
    .pulse_out(pulse_out),
    .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  int exp_pulses = 0;
  int obs_pulses = 0;
  int cyc = 0;

  // Reference model: sampled-input history, accepted level and run of opposite samples.
  logic m_p1, m_p2, m_v1, m_v2, m_armed, m_lvl, m_stuck;
  int   m_run, m_hold;

  task automatic step(input logic r, input logic s_in);
    logic s, sv, pl;
    @(negedge clk);
    rst   = r;
    sw_in = s_in;
    pl    = 1'b0;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_v1 = 0; m_v2 = 0; m_armed = 0;
      m_lvl = 0; m_run = 0; m_hold = 0; m_stuck = 0;
    end else begin
      s  = m_p2;
      sv = m_v2;
      if (m_hold >= HoldLimit) m_stuck = 1'b1;
      m_hold = m_lvl ? ((m_hold < HoldMax) ? m_hold + 1 : m_hold) : 0;
      if (s != m_lvl && (m_lvl || m_armed)) begin
        m_run++;
        if (m_run == Deb + 1) begin
          m_lvl = s;
          m_run = 0;
`ifdef SWDET_RELEASE_PULSE_EN
          pl = ~s;
`else
          pl = s;
`endif
        end
      end else begin
        m_run = 0;
      end
      if (sv && !s) m_armed = 1'b1;
      m_p2 = m_p1; m_v2 = m_v1; m_p1 = s_in; m_v1 = 1'b1;
    end
    if (pl) exp_pulses++;
    exp_q.push_back({m_lvl, pl, m_stuck});
  endtask

  task automatic hold_level(input logic s_in, input int n);
    for (int i = 0; i < n; i++) step(1'b0, s_in);
  endtask

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse_out === 1'b1) obs_pulses++;
        if ({level_out, pulse_out, stuck_err} !== e) begin
          fails++;
          $display("FAIL outputs cycle %0d: {level,pulse,stuck} got %b%b%b expected %b",
                   cyc, level_out, pulse_out, stuck_err, e);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    hold_level(1'b0, 6);
    // Clean press and release
    hold_level(1'b1, 20); hold_level(1'b0, 20);
    // Short glitch rejected
    hold_level(1'b1, 3);  hold_level(1'b0, 10);
    // Release bounce
    hold_level(1'b1, 10); hold_level(1'b0, 2); hold_level(1'b1, 10); hold_level(1'b0, 20);
    // Stuck detection, sticky across release and second press, cleared by reset
    hold_level(1'b1, 50); hold_level(1'b0, 20); hold_level(1'b1, 12); hold_level(1'b0, 20);
    step(1'b1, 1'b0);     hold_level(1'b0, 5);
    // Reset while debouncing a press; held high must not re-trigger
    hold_level(1'b1, 4);  step(1'b1, 1'b1); hold_level(1'b1, 15);
    hold_level(1'b0, 10); hold_level(1'b1, 15); hold_level(1'b0, 15);
    // Randomised bounce/hold segments with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      n = $urandom_range(0, 9);
      n = (n < 4) ? $urandom_range(1, 4) : (n < 8) ? $urandom_range(5, 15) : $urandom_range(30, 45);
      for (int i = 0; i < n; i++)
        step(($urandom_range(0, 199) == 0), logic'(seg[0] ^ ($urandom_range(0, 19) == 0)));
    end
    hold_level(1'b0, 20);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    checks++;
    if (obs_pulses != exp_pulses) begin
      fails++;
      $display("FAIL pulse_count: got %0d required %0d", obs_pulses, exp_pulses);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
